// File: rtl/perf_monitor_pkg.sv
// Shared register map, bit positions and run-state encoding for the perf_monitor block.
package perf_monitor_pkg;

   localparam logic [7:0] ADDR_CTRL      = 8'h00;
   localparam logic [7:0] ADDR_STATUS    = 8'h04;
   localparam logic [7:0] ADDR_TOHOST    = 8'h08;
   localparam logic [7:0] ADDR_OVF       = 8'h0C;
   localparam logic [7:0] ADDR_SNAP_BASE = 8'h10;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_CLEAR_BIT = 1;
   localparam int CTRL_SNAP_BIT  = 2;

   localparam int STATUS_DONE_BIT    = 0;
   localparam int STATUS_PASS_BIT    = 1;
   localparam int STATUS_FAIL_BIT    = 2;
   localparam int STATUS_TIMEOUT_BIT = 3;

   localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_0777;

   typedef enum logic [1:0] {
      RUN_ACTIVE  = 2'd0,
      RUN_PASS    = 2'd1,
      RUN_FAIL    = 2'd2,
      RUN_TIMEOUT = 2'd3
   } run_state_e;

   // Each channel owns an 8-byte window: low word, then high word.
   function automatic logic [7:0] snap_lo_addr(input int ch);
      return ADDR_SNAP_BASE + 8'(ch * 8);
   endfunction

   function automatic logic [31:0] snap_word(input logic [63:0] value, input logic hi);
      return hi ? value[63:32] : value[31:0];
   endfunction

endpackage

// File: rtl/perf_monitor_perf_counter.sv
// One event channel: free-running counter, snapshot copy and sticky wrap flag.
module perf_counter
   import perf_monitor_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clear,
   input  logic             i_snap,
   input  logic             i_ovf_clr,
   output logic [CNT_W-1:0] o_snap,
   output logic             o_ovf
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ALL  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_snap;
   logic             r_ovf;
   logic             w_wrap;

   // A clear suppresses the increment, so it can never report a wrap.
   assign w_wrap = i_inc & ~i_clear & (r_cnt == CNT_ALL);

   // Counter, snapshot and overflow state; snapshot sees the pre-update count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= CNT_ZERO;
         r_snap <= CNT_ZERO;
         r_ovf  <= 1'b0;
      end else begin
         if (i_clear) begin
            r_cnt <= CNT_ZERO;
         end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (i_snap) begin
            r_snap <= r_cnt;
         end
         if (w_wrap) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_snap = r_snap;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: cycle/event counters, snapshot registers, tohost pass/fail
// capture and a run watchdog behind a simple word-addressed register bus.
module perf_monitor
   import perf_monitor_pkg::*;
#(
   parameter int          NEVT      = 4,
   parameter int          CNT_W     = 64,
   parameter int          TIMEOUT   = 1500,
   parameter logic [31:0] PASS_CODE = DEFAULT_PASS_CODE
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NEVT-1:0] event_i,
   input  logic [7:0]      bus_addr_i,
   input  logic            bus_wvalid_i,
   input  logic [31:0]     bus_wdata_i,
   input  logic            bus_rvalid_i,
   output logic [31:0]     bus_rdata_o,
   output logic            bus_rdata_valid_o,
   output logic            done_o,
   output logic            pass_o,
   output logic            fail_o,
   output logic            timeout_o
);

   localparam int          NCH       = NEVT + 1;
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

   logic             w_wr_ctrl;
   logic             w_wr_tohost;
   logic             w_wr_ovf;
   logic             w_clear;
   logic             w_snap;
   logic [NCH-1:0]   w_evt;
   logic [NCH-1:0]   w_inc;
   logic [NCH-1:0]   w_ovf_clr;
   logic [NCH-1:0]   w_ovf;
   logic [CNT_W-1:0] w_snap_val [NCH];
   logic [31:0]      w_wdog_next;
   logic             w_wd_hit;
   logic [31:0]      w_ctrl_rd;
   logic [31:0]      w_status_rd;
   logic [31:0]      w_snap_rd;
   logic [31:0]      w_rd_mux;

   logic             r_en;
   logic [31:0]      r_tohost;
   logic [31:0]      r_wdog;
   run_state_e       r_state;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic             r_timeout;
   logic [31:0]      r_rdata;
   logic             r_rvalid;

   assign w_wr_ctrl   = bus_wvalid_i & (bus_addr_i == ADDR_CTRL);
   assign w_wr_ovf    = bus_wvalid_i & (bus_addr_i == ADDR_OVF);
   assign w_wr_tohost = bus_wvalid_i & (bus_addr_i == ADDR_TOHOST) & ~r_done;
   assign w_clear     = w_wr_ctrl & bus_wdata_i[CTRL_CLEAR_BIT];
   assign w_snap      = w_wr_ctrl & bus_wdata_i[CTRL_SNAP_BIT];
   assign w_ovf_clr   = w_wr_ovf ? bus_wdata_i[NCH-1:0] : {NCH{1'b0}};

   // Channel 0 is the cycle counter, so its "event" is always present.
   assign w_evt = {event_i, 1'b1};
   assign w_inc = (r_en & ~r_done) ? w_evt : {NCH{1'b0}};

   assign w_wdog_next = r_wdog + 32'd1;
   assign w_wd_hit    = (TIMEOUT != 0) & (w_wdog_next == TIMEOUT_C);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      perf_counter #(
         .CNT_W (CNT_W)
      ) u_ctr (
         .i_clk     (clk_i),
         .i_rst_n   (rst_ni),
         .i_inc     (w_inc[g]),
         .i_clear   (w_clear),
         .i_snap    (w_snap),
         .i_ovf_clr (w_ovf_clr[g]),
         .o_snap    (w_snap_val[g]),
         .o_ovf     (w_ovf[g])
      );
   end

   // Enable bit; clear and snap are pulses taken straight from the write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en <= bus_wdata_i[CTRL_EN_BIT];
      end
   end

   // Watchdog runs from reset release and parks once the run has ended.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wdog <= 32'd0;
      end else if ((TIMEOUT != 0) && !r_done) begin
         r_wdog <= w_wdog_next;
      end
   end

   // Run-state FSM; a tohost write takes priority over a same-cycle expiry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= RUN_ACTIVE;
         r_tohost  <= 32'd0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            RUN_ACTIVE: begin
               if (w_wr_tohost) begin
                  r_tohost <= bus_wdata_i;
                  r_done   <= 1'b1;
                  if (bus_wdata_i == PASS_CODE) begin
                     r_state <= RUN_PASS;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= RUN_FAIL;
                     r_fail  <= 1'b1;
                  end
               end else if (w_wd_hit) begin
                  r_state   <= RUN_TIMEOUT;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            RUN_PASS, RUN_FAIL, RUN_TIMEOUT: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= RUN_ACTIVE;
            end
         endcase
      end
   end

   // Control and status read images.
   always_comb begin
      w_ctrl_rd                       = 32'd0;
      w_ctrl_rd[CTRL_EN_BIT]          = r_en;
      w_status_rd                     = 32'd0;
      w_status_rd[STATUS_DONE_BIT]    = r_done;
      w_status_rd[STATUS_PASS_BIT]    = r_pass;
      w_status_rd[STATUS_FAIL_BIT]    = r_fail;
      w_status_rd[STATUS_TIMEOUT_BIT] = r_timeout;
   end

   // Snapshot window decode; at most one term can match a given offset.
   always_comb begin
      w_snap_rd = 32'd0;
      for (int i = 0; i < NCH; i++) begin
         w_snap_rd = w_snap_rd
            | ((bus_addr_i == snap_lo_addr(i))
               ? snap_word(64'(w_snap_val[i]), 1'b0) : 32'd0)
            | ((bus_addr_i == (snap_lo_addr(i) + 8'd4))
               ? snap_word(64'(w_snap_val[i]), 1'b1) : 32'd0);
      end
   end

   // Register read multiplexer; anything unmapped falls through to zero.
   always_comb begin
      case (bus_addr_i)
         ADDR_CTRL:   w_rd_mux = w_ctrl_rd;
         ADDR_STATUS: w_rd_mux = w_status_rd;
         ADDR_TOHOST: w_rd_mux = r_tohost;
         ADDR_OVF:    w_rd_mux = {{(32-NCH){1'b0}}, w_ovf};
         default:     w_rd_mux = w_snap_rd;
      endcase
   end

   // Read response registered one cycle after the request, from pre-write state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'd0;
      end else begin
         r_rvalid <= bus_rvalid_i;
         r_rdata  <= bus_rvalid_i ? w_rd_mux : 32'd0;
      end
   end

   assign bus_rdata_o       = r_rdata;
   assign bus_rdata_valid_o = r_rvalid;
   assign done_o            = r_done;
   assign pass_o            = r_pass;
   assign fail_o            = r_fail;
   assign timeout_o         = r_timeout;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: three parameterisations share one bus, reads
// are checked through an expected-value queue.
module tb_perf_monitor;
   import perf_monitor_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  evt;
   logic [7:0]  addr;
   logic        wv;
   logic [31:0] wd;
   logic        rv;

   logic [31:0] m_rdata, o_rdata, t_rdata, sel_rdata;
   logic        m_valid, o_valid, t_valid, sel_valid;
   logic        m_done, m_pass, m_fail, m_tmo;
   logic        o_done, o_pass, o_fail, o_tmo;
   logic        t_done, t_pass, t_fail, t_tmo;

   int          total = 0;
   int          bad   = 0;
   int          sel   = 0;
   int          pulses;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   perf_monitor u_main (
      .clk_i(clk), .rst_ni(rst_n), .event_i(evt),
      .bus_addr_i(addr), .bus_wvalid_i(wv), .bus_wdata_i(wd), .bus_rvalid_i(rv),
      .bus_rdata_o(m_rdata), .bus_rdata_valid_o(m_valid),
      .done_o(m_done), .pass_o(m_pass), .fail_o(m_fail), .timeout_o(m_tmo));

   perf_monitor #(.NEVT(2), .CNT_W(33), .TIMEOUT(0)) u_w33 (
      .clk_i(clk), .rst_ni(rst_n), .event_i(evt[1:0]),
      .bus_addr_i(addr), .bus_wvalid_i(wv), .bus_wdata_i(wd), .bus_rvalid_i(rv),
      .bus_rdata_o(o_rdata), .bus_rdata_valid_o(o_valid),
      .done_o(o_done), .pass_o(o_pass), .fail_o(o_fail), .timeout_o(o_tmo));

   perf_monitor #(.NEVT(1), .CNT_W(40), .TIMEOUT(20)) u_wd (
      .clk_i(clk), .rst_ni(rst_n), .event_i(evt[0:0]),
      .bus_addr_i(addr), .bus_wvalid_i(wv), .bus_wdata_i(wd), .bus_rvalid_i(rv),
      .bus_rdata_o(t_rdata), .bus_rdata_valid_o(t_valid),
      .done_o(t_done), .pass_o(t_pass), .fail_o(t_fail), .timeout_o(t_tmo));

   always_comb begin
      case (sel)
         0:       begin sel_rdata = m_rdata; sel_valid = m_valid; end
         1:       begin sel_rdata = o_rdata; sel_valid = o_valid; end
         default: begin sel_rdata = t_rdata; sel_valid = t_valid; end
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      addr = a; wd = d; wv = 1'b1;
      @(negedge clk);
      wv = 1'b0;
   endtask

   // Pops the expectation pushed at issue time when the response appears.
   task automatic collect();
      logic [31:0] ev;
      string       t;
      ev = exp_q.pop_front();
      t  = tag_q.pop_front();
      chk({t, "_vld"}, {63'd0, sel_valid}, 64'd1);
      chk(t, {32'd0, sel_rdata}, {32'd0, ev});
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
      addr = a; rv = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      rv = 1'b0;
      collect();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; evt = 4'd0; wv = 1'b0; rv = 1'b0; addr = 8'd0; wd = 32'd0;
      #1;
      chk("rst_outputs", {58'd0, m_done, m_pass, m_fail, m_tmo, m_valid, |m_rdata}, 64'd0);
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b1; evt = 4'd0; wv = 1'b0; rv = 1'b0; addr = 8'd0; wd = 32'd0;
      do_reset();

      // Watchdog: expiry on the 20th rising edge after release.
      tick(19);
      chk("wd_before", {63'd0, t_tmo}, 64'd0);
      tick(1);
      chk("wd_flags", {60'd0, t_tmo, t_fail, t_pass, t_done}, 64'h9);
      sel = 2;
      rd(ADDR_STATUS, 32'h9, "wd_status");
      sel = 0;
      chk("main_not_done", {63'd0, m_done}, 64'd0);
      rd(ADDR_CTRL,   32'd0, "rst_ctrl");
      rd(ADDR_TOHOST, 32'd0, "rst_tohost");
      rd(ADDR_OVF,    32'd0, "rst_ovf");
      rd(8'h10,       32'd0, "rst_snap0");
      rd(8'h38,       32'd0, "unmapped_38");

      // Ten channel-1 events over twenty enabled cycles, then snapshot.
      wr(ADDR_CTRL, 32'h1);
      for (int i = 0; i < 10; i++) begin
         evt = 4'b0001; tick(1);
         evt = 4'b0000; tick(1);
      end
      wr(ADDR_CTRL, 32'h5);
      rd(8'h18, 32'd10, "ch1_lo");
      rd(8'h1C, 32'd0,  "ch1_hi");
      rd(8'h10, 32'd20, "ch0_cycles");
      rd(8'h20, 32'd0,  "ch2_idle");

      // Read and write to CTRL in the same cycle returns the old value.
      addr = ADDR_CTRL; wd = 32'h0; wv = 1'b1; rv = 1'b1;
      exp_q.push_back(32'h1); tag_q.push_back("rw_same_cycle");
      @(negedge clk);
      wv = 1'b0; rv = 1'b0;
      collect();
      rd(ADDR_CTRL, 32'h0, "ctrl_after_write");

      // Clear coincident with an event.
      wr(ADDR_CTRL, 32'h1);
      evt = 4'b0001; addr = ADDR_CTRL; wd = 32'h3; wv = 1'b1;
      tick(1);
      wv = 1'b0; evt = 4'b0000;
      wr(ADDR_CTRL, 32'h4);
      rd(8'h18, 32'd0, "clr_vs_evt_ch1");
      rd(8'h10, 32'd0, "clr_ch0");
      wr(ADDR_STATUS, 32'hF);
      rd(ADDR_STATUS, 32'd0, "ro_status_write");
      wr(8'h40, 32'hFFFF_FFFF);
      rd(8'h40, 32'd0, "unmapped_write");

      // 33-bit wrap: preset all-ones, two events, W1C in the wrap cycle.
      sel = 1;
      force u_w33.g_ch[1].u_ctr.r_cnt = 33'h1_FFFF_FFFF;
      #1;
      release u_w33.g_ch[1].u_ctr.r_cnt;
      wr(ADDR_CTRL, 32'h4);
      rd(8'h18, 32'hFFFF_FFFF, "w33_preset_lo");
      rd(8'h1C, 32'h1,         "w33_preset_hi");
      wr(ADDR_CTRL, 32'h1);
      evt = 4'b0001; addr = ADDR_OVF; wd = 32'h2; wv = 1'b1;
      tick(1);
      wv = 1'b0;
      tick(1);
      evt = 4'b0000;
      wr(ADDR_CTRL, 32'h4);
      rd(8'h18,    32'd1, "w33_wrap_lo");
      rd(8'h1C,    32'd0, "w33_wrap_hi");
      rd(ADDR_OVF, 32'h2, "w33_ovf_set");
      wr(ADDR_OVF, 32'h2);
      rd(ADDR_OVF, 32'h0, "w33_ovf_w1c");
      sel = 0;

      // Pass code, then a later non-pass write is ignored.
      wr(ADDR_TOHOST, 32'h777);
      chk("pass_flags", {60'd0, m_tmo, m_fail, m_pass, m_done}, 64'h3);
      rd(ADDR_STATUS, 32'h3, "pass_status");
      tick(1);
      chk("vld_one_cycle", {63'd0, m_valid}, 64'd0);
      rd(ADDR_TOHOST, 32'h777, "pass_tohost");
      wr(ADDR_TOHOST, 32'h5);
      rd(ADDR_STATUS, 32'h3,   "pass_sticky_status");
      rd(ADDR_TOHOST, 32'h777, "pass_sticky_tohost");

      // Reset while a read response is outstanding.
      addr = ADDR_STATUS; rv = 1'b1;
      @(posedge clk);
      #1;
      chk("inflight_vld", {63'd0, m_valid}, 64'd1);
      rst_n = 1'b0; rv = 1'b0;
      #1;
      chk("rst_abort", {31'd0, m_valid, m_rdata}, 64'd0);
      tick(2);
      rst_n = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) pulses++;
      end
      chk("no_vld_after_rst", 64'(pulses), 64'd0);
      rd(ADDR_TOHOST, 32'd0, "tohost_after_rst");

      // Fail code freezes the counters.
      wr(ADDR_CTRL, 32'h1);
      tick(3);
      wr(ADDR_TOHOST, 32'hDEAD);
      chk("fail_flags", {60'd0, m_tmo, m_fail, m_pass, m_done}, 64'h5);
      rd(ADDR_TOHOST, 32'hDEAD, "fail_tohost");
      rd(ADDR_STATUS, 32'h5,    "fail_status");
      wr(ADDR_CTRL, 32'h5);
      rd(8'h10, 32'd4, "frozen_snap_a");
      tick(10);
      evt = 4'b0001;
      wr(ADDR_CTRL, 32'h5);
      evt = 4'b0000;
      rd(8'h10, 32'd4, "frozen_snap_b");
      wr(ADDR_TOHOST, 32'h777);
      chk("fail_sticky", {60'd0, m_tmo, m_fail, m_pass, m_done}, 64'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter NEVT, default 4: number of external event channels (1..15).
REQ-002 SHALL have parameter CNT_W, default 64: counter width (33..64).
REQ-003 SHALL have parameter TIMEOUT, default 1500: cycle limit; 0 disables the watchdog.
REQ-004 SHALL have parameter PASS_CODE, default 32'h777: tohost value meaning pass.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port event_i, input, NEVT: per-cycle event pulses; bit k drives channel k+1.
REQ-008 SHALL have port bus_addr_i, input, 8: register byte offset, word aligned.
REQ-009 SHALL have port bus_wvalid_i, input, 1: write strobe.
REQ-010 SHALL have port bus_wdata_i, input, 32: write data.
REQ-011 SHALL have port bus_rvalid_i, input, 1: read request.
REQ-012 SHALL have port bus_rdata_o, output, 32: read data.
REQ-013 SHALL have port bus_rdata_valid_o, output, 1: read data valid.
REQ-014 SHALL have port done_o, output, 1: run finished (sticky).
REQ-015 SHALL have port pass_o, output, 1: finished with pass.
REQ-016 SHALL have port fail_o, output, 1: finished with a non-pass code.
REQ-017 SHALL have port timeout_o, output, 1: finished by watchdog.

Function
REQ-018 SHALL implement NEVT+1 counters of CNT_W bits; channel 0 counts cycles, channel k counts cycles with event_i[k-1]=1.
REQ-019 SHALL increment a counter only when CTRL.en=1 and done_o=0, i.e. counters freeze once done_o is set.
REQ-020 SHALL define registers: 0x00 CTRL (bit0 en RW; bit1 clear and bit2 snap, write-1 self-clearing, read 0), 0x04 STATUS RO {timeout,fail,pass,done} in bits 3..0, 0x08 TOHOST, 0x0C OVF (bit i sticky, W1C), 0x10+8*i snapshot low word, 0x14+8*i snapshot high word (zero-extended).
REQ-021 SHALL zero all counters on the cycle after CTRL.clear is written; clear SHALL beat a coincident increment.
REQ-022 SHALL copy all live counters into snapshot registers on CTRL.snap, capturing the pre-increment value of that cycle.
REQ-023 SHALL wrap a counter from all-ones to 0 and set OVF bit i in the same cycle; a coincident OVF W1C SHALL lose to the set.
REQ-024 SHALL, on a TOHOST write while done_o=0, set done_o plus pass_o if data==PASS_CODE, else fail_o, and latch data into TOHOST (readable).
REQ-025 SHALL ignore TOHOST writes while done_o=1.
REQ-026 SHALL run a watchdog counting every cycle from reset release; when it reaches TIMEOUT with done_o=0, set done_o and timeout_o.
REQ-027 SHALL let a TOHOST write beat a watchdog expiry in the same cycle.
REQ-028 SHALL return read data with one-cycle latency: bus_rdata_valid_o is high exactly the cycle after bus_rvalid_i.
REQ-029 SHALL return pre-write contents when a read and a write to the same offset occur in the same cycle.
REQ-030 SHALL read 0 from unmapped offsets and ignore writes to them and to RO registers.
REQ-031 SHALL keep done_o, pass_o, fail_o and timeout_o mutually consistent: at most one of pass/fail/timeout, and done_o equal to their OR.

Reset
REQ-032 SHALL, on rst_ni low, immediately clear counters, snapshots, OVF, TOHOST, watchdog, CTRL (en=0), bus_rdata_o, bus_rdata_valid_o, done_o, pass_o, fail_o and timeout_o to 0.
REQ-033 SHALL abort any read in flight when reset asserts mid-operation, producing no valid pulse after release.

Structure
REQ-034 SHALL place register offsets, CTRL and STATUS bit indices and the default PASS_CODE in package perf_monitor_pkg.
REQ-035 SHALL instantiate sub-module perf_counter once per channel (counter, snapshot, sticky overflow).

Verification
REQ-036 SHALL show that CTRL=1, then 10 event_i[0] pulses, then snap gives channel 1 snapshot low word = 10 and high word = 0.
REQ-037 SHALL show that with CNT_W=33, a counter preset near all-ones and 2 events gives the wrap value 1 and OVF bit set; W1C in the wrap cycle leaves the bit at 1.
REQ-038 SHALL show that TOHOST=0x777 gives pass_o=1 and STATUS=0x3; a following TOHOST=0x5 leaves the state unchanged.
REQ-039 SHALL show that TOHOST=0xDEAD gives fail_o=1 and TOHOST readback 0xDEAD, with counters frozen on later cycles.
REQ-040 SHALL show that with TIMEOUT=20 and no writes, timeout_o rises 20 cycles after reset release and STATUS=0x9.
REQ-041 SHALL show that clear coincident with an event yields 0, and reset asserted with a read pending gives no bus_rdata_valid_o pulse.
